// File: rtl/ahb_splitter_n.sv
// AHB-Lite slave-side splitter: decodes one bus slave port onto NS downstream
// slaves by address page, answers unmapped or isolated accesses with a
// two-cycle ERROR, isolates slaves that stall past the watchdog limit, and
// keeps a small error log (count and last erroring address).
module ahb_splitter_n #(
   parameter int NS      = 4,
   parameter int PAGE_HI = 31,
   parameter int PAGE_LO = 24,
   parameter logic [NS*(PAGE_HI-PAGE_LO+1)-1:0] PAGE_BASES = {8'h70, 8'h40, 8'h48, 8'h60},
   parameter int TIMEOUT = 16,
   parameter int CW      = 8
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             HSEL,
   input  logic [31:0]      HADDR,
   input  logic [1:0]       HTRANS,
   input  logic             HREADY,
   output logic             HREADYOUT,
   output logic [31:0]      HRDATA,
   output logic             HRESP,
   output logic [NS-1:0]    S_HSEL,
   input  logic [NS-1:0]    S_HREADYOUT,
   input  logic [NS*32-1:0] S_HRDATA,
   input  logic [NS-1:0]    S_HRESP,
   output logic [NS-1:0]    HUNG,
   input  logic             CLR_HUNG,
   output logic             TO_IRQ,
   output logic [CW-1:0]    ERR_CNT,
   output logic [31:0]      LAST_ERR_ADDR,
   input  logic             CLR_ERR
);

   localparam int PW = PAGE_HI - PAGE_LO + 1;
   localparam int IW = (NS > 1) ? $clog2(NS) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [31:0] FILL_DATA = 32'hDEAD_BEEF;

   // Data-phase ownership: nobody, a real slave, or the built-in error slave.
   typedef enum logic [1:0] {
      ST_NONE,
      ST_PASS,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   owner, owner_nxt;
   logic [TW-1:0]   cnt, cnt_nxt;
   logic [31:0]     aaddr;
   logic            hit;
   logic [IW-1:0]   hit_idx;
   logic            acc;
   logic            launch;
   logic            fire;
   logic            err_end;
   logic [31:0]     s_rdata [NS];
   logic            unused_htrans0;

   assign unused_htrans0 = HTRANS[0];
   assign acc            = HSEL & HREADY & HTRANS[1];

   for (genvar g = 0; g < NS; g++) begin : g_rdata
      assign s_rdata[g] = S_HRDATA[g*32 +: 32];
   end

   // Page decode over non-isolated slaves; lowest index wins on overlap.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      hit     = 1'b0;
      hit_idx = '0;
      S_HSEL  = '0;
      for (int i = 0; i < NS; i++) begin
         if (!hit && !HUNG[i] && (HADDR[PAGE_HI:PAGE_LO] == PAGE_BASES[i*PW +: PW])) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
      end
      if (HSEL && hit) S_HSEL[hit_idx] = 1'b1;
   end

   // Next data-phase owner and watchdog; NONE, ERR2 and a completed PASS all start the next phase.
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      cnt_nxt   = cnt;
      launch    = 1'b0;
      fire      = 1'b0;
      case (state)
         ST_NONE, ST_ERR2: launch = 1'b1;
         ST_PASS: begin
            if (S_HREADYOUT[owner]) begin
               launch = 1'b1;
            end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
               state_nxt = ST_ERR1;
               fire      = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_ERR1: state_nxt = ST_ERR2;
         default: state_nxt = ST_NONE;
      endcase
      if (launch) begin
         if (acc && hit) begin
            state_nxt = ST_PASS;
            owner_nxt = hit_idx;
            cnt_nxt   = '0;
         end else if (acc) begin
            state_nxt = ST_ERR1;
         end else begin
            state_nxt = ST_NONE;
         end
      end
   end

   // Response mux back to the bus.
   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      HRDATA    = FILL_DATA;
      case (state)
         ST_PASS: begin
            HREADYOUT = S_HREADYOUT[owner];
            HRESP     = S_HRESP[owner];
            HRDATA    = s_rdata[owner];
         end
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
         end
         ST_ERR2: HRESP = 1'b1;
         default: ;
      endcase
   end

   assign err_end = HREADYOUT & HRESP;

   // Owner, watchdog counter and the captured address of the accepted transfer.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state <= ST_NONE;
         owner <= '0;
         cnt   <= '0;
         aaddr <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
         state <= state_nxt;
         owner <= owner_nxt;
         cnt   <= cnt_nxt;
         if (acc) aaddr <= HADDR;
      end
   end

   // Sticky hung-slave flags and the one-cycle timeout interrupt; clear beats set.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         HUNG   <= '0;
         TO_IRQ <= 1'b0;
      end else begin
         TO_IRQ <= fire;
         if (CLR_HUNG)  HUNG        <= '0;
         else if (fire) HUNG[owner] <= 1'b1;
      end
   end

   // Error log, updated on the last cycle of every ERROR response; clear beats update.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ERR_CNT       <= '0;
         LAST_ERR_ADDR <= '0;
      end else if (CLR_ERR) begin
         ERR_CNT       <= '0;
         LAST_ERR_ADDR <= '0;
      end else if (err_end) begin
         if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
         LAST_ERR_ADDR <= aaddr;
      end
   end

endmodule

// File: tb/tb_ahb_splitter_n.sv
// Self-checking bench for ahb_splitter_n with default parameters. Expected
// bus responses are queued when a transfer is issued and popped as each
// data-phase cycle is observed.
module tb_ahb_splitter_n;

   localparam int          NS      = 4;
   localparam int          TIMEOUT = 16;
   localparam logic [31:0] DB      = 32'hDEAD_BEEF;

   logic             HCLK = 1'b0;
   logic             HRESETn = 1'b0;
   logic             HSEL = 1'b0;
   logic [31:0]      HADDR = '0;
   logic [1:0]       HTRANS = 2'b00;
   logic             HREADY;
   logic             HREADYOUT;
   logic [31:0]      HRDATA;
   logic             HRESP;
   logic [NS-1:0]    S_HSEL;
   logic [NS-1:0]    S_HREADYOUT = '1;
   logic [NS*32-1:0] S_HRDATA = '0;
   logic [NS-1:0]    S_HRESP = '0;
   logic [NS-1:0]    HUNG;
   logic             CLR_HUNG = 1'b0;
   logic             TO_IRQ;
   logic [7:0]       ERR_CNT;
   logic [31:0]      LAST_ERR_ADDR;
   logic             CLR_ERR = 1'b0;

   // Single-master bus: the splitter's own ready is the bus ready.
   assign HREADY = HREADYOUT;

   ahb_splitter_n dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
      .S_HSEL(S_HSEL), .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA), .S_HRESP(S_HRESP),
      .HUNG(HUNG), .CLR_HUNG(CLR_HUNG), .TO_IRQ(TO_IRQ), .ERR_CNT(ERR_CNT),
      .LAST_ERR_ADDR(LAST_ERR_ADDR), .CLR_ERR(CLR_ERR)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic        rdy;
      logic        resp;
      logic [31:0] data;
   } beat_t;

   beat_t       exp_q[$];
   int          total = 0;
   int          bad = 0;
   logic [7:0]  pages [NS] = '{8'h60, 8'h48, 8'h40, 8'h70};
   logic [NS-1:0] m_hung = '0;
   int          m_err = 0;
   logic [31:0] m_last = '0;

   function automatic int decode(input logic [31:0] a);
      for (int i = 0; i < NS; i++)
         if (a[31:24] == pages[i] && !m_hung[i]) return i;
      return -1;
   endfunction

   task automatic push(input logic r, input logic s, input logic [31:0] d);
      beat_t b;
      b.rdy = r; b.resp = s; b.data = d;
      exp_q.push_back(b);
   endtask

   task automatic bump_err(input logic [31:0] a);
      if (m_err < 255) m_err++;
      m_last = a;
   endtask

   task automatic mid();
      @(negedge HCLK);
   endtask

   task automatic nxt();
      @(posedge HCLK);
      #1;
   endtask

   task automatic pop_check(input string tag);
      beat_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL %s: scoreboard empty, got rdy=%b resp=%b data=%h", tag, HREADYOUT, HRESP, HRDATA);
      end else begin
         e = exp_q.pop_front();
         if ({HREADYOUT, HRESP, HRDATA} !== {e.rdy, e.resp, e.data}) begin
            bad++;
            $display("FAIL %s: got rdy=%b resp=%b data=%h, want rdy=%b resp=%b data=%h",
                     tag, HREADYOUT, HRESP, HRDATA, e.rdy, e.resp, e.data);
         end
      end
   endtask

   task automatic check_log(input string tag);
      total++;
      if (ERR_CNT !== 8'(m_err) || LAST_ERR_ADDR !== m_last || HUNG !== m_hung) begin
         bad++;
         $display("FAIL %s: got cnt=%0d last=%h hung=%b, want cnt=%0d last=%h hung=%b",
                  tag, ERR_CNT, LAST_ERR_ADDR, HUNG, m_err, m_last, m_hung);
      end
   endtask

   task automatic check_sel(input string tag, input logic [NS-1:0] want);
      total++;
      if (S_HSEL !== want) begin
         bad++;
         $display("FAIL %s: S_HSEL got %b want %b", tag, S_HSEL, want);
      end
   endtask

   // One non-pipelined transfer: address phase, full data phase, one idle cycle.
   // waits >= TIMEOUT means the target slave never becomes ready.
   task automatic run_xfer(input logic [31:0] addr, input logic [1:0] trans, input int waits,
                           input logic serr, input logic [31:0] data, input string tag);
      int t;
      int n;
      logic to;
      logic [NS-1:0] want_sel;
      logic r;
      logic s;
      t = decode(addr);
      want_sel = (t >= 0) ? (NS'(1) << t) : '0;
      HSEL = 1'b1; HADDR = addr; HTRANS = trans;
      push(1'b1, 1'b0, DB);
      mid();
      pop_check({tag, "_addr"});
      check_sel({tag, "_sel"}, want_sel);
      to = 1'b0;
      n = 0;
      if (!trans[1]) begin
         n = 0;
      end else if (t < 0) begin
         push(1'b0, 1'b1, DB); push(1'b1, 1'b1, DB);
         n = 2; bump_err(addr);
      end else if (waits >= TIMEOUT) begin
         repeat (TIMEOUT) push(1'b0, 1'b0, data);
         push(1'b0, 1'b1, DB); push(1'b1, 1'b1, DB);
         n = TIMEOUT + 2; to = 1'b1; m_hung[t] = 1'b1; bump_err(addr);
      end else begin
         repeat (waits) push(1'b0, 1'b0, data);
         if (serr) begin
            push(1'b0, 1'b1, data); push(1'b1, 1'b1, data);
            n = waits + 2; bump_err(addr);
         end else begin
            push(1'b1, 1'b0, data);
            n = waits + 1;
         end
      end
      nxt();
      HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0;
      for (int k = 0; k < n; k++) begin
         if (t >= 0) begin
            if (waits >= TIMEOUT || k < waits) begin r = 1'b0; s = 1'b0; end
            else if (serr)                     begin r = (k != waits); s = 1'b1; end
            else                               begin r = 1'b1; s = 1'b0; end
            S_HRDATA[t*32 +: 32] = data;
            S_HREADYOUT[t] = r;
            S_HRESP[t] = s;
         end
         mid();
         pop_check(tag);
         total++;
         if (TO_IRQ !== (to && k == TIMEOUT)) begin
            bad++;
            $display("FAIL %s_irq: cycle %0d TO_IRQ got %b want %b", tag, k, TO_IRQ, to && k == TIMEOUT);
         end
         nxt();
      end
      S_HREADYOUT = '1;
      S_HRESP = '0;
      push(1'b1, 1'b0, DB);
      mid();
      pop_check({tag, "_idle"});
      check_log({tag, "_log"});
      nxt();
   endtask

   task automatic test_reset();
      #12;
      total++;
      if ({HREADYOUT, HRESP, HRDATA, HUNG, ERR_CNT, LAST_ERR_ADDR, TO_IRQ, S_HSEL} !==
          {1'b1, 1'b0, DB, 4'b0, 8'd0, 32'd0, 1'b0, 4'b0}) begin
         bad++;
         $display("FAIL reset: got rdy=%b resp=%b data=%h hung=%b cnt=%0d last=%h irq=%b sel=%b",
                  HREADYOUT, HRESP, HRDATA, HUNG, ERR_CNT, LAST_ERR_ADDR, TO_IRQ, S_HSEL);
      end
      @(negedge HCLK);
      HRESETn = 1'b1;
      nxt();
   endtask

   task automatic test_basic();
      run_xfer(32'h6000_0010, 2'b10, 0, 1'b0, 32'h1234_5678, "rd_s0");
      run_xfer(32'h7000_0100, 2'b10, 3, 1'b0, 32'h3333_0003, "rd_s3_wait");
      run_xfer(32'h4000_0004, 2'b11, 1, 1'b0, 32'h2222_0002, "rd_s2_seq");
   endtask

   task automatic test_default();
      run_xfer(32'h5000_0000, 2'b10, 0, 1'b0, 32'h0, "dflt");
      run_xfer(32'h5000_0000, 2'b00, 0, 1'b0, 32'h0, "dflt_idle");
      run_xfer(32'h6000_0000, 2'b01, 0, 1'b0, 32'h0, "s0_busy");
   endtask

   task automatic test_timeout();
      run_xfer(32'h4800_0000, 2'b10, 100, 1'b0, 32'hCAFE_0001, "timeout");
      run_xfer(32'h4800_0000, 2'b10, 0, 1'b0, 32'hCAFE_0002, "hung_dflt");
      CLR_HUNG = 1'b1;
      nxt();
      CLR_HUNG = 1'b0;
      m_hung = '0;
      mid();
      check_log("clr_hung");
      nxt();
      run_xfer(32'h4800_0000, 2'b10, 0, 1'b0, 32'hBEEF_0048, "unhung");
   endtask

   task automatic test_slave_err();
      run_xfer(32'h4000_0000, 2'b10, 1, 1'b1, 32'h0000_E222, "s2_err");
      for (int i = 0; i < 300 && m_err < 255; i++)
         run_xfer(32'h5000_0000 + i, 2'b10, 0, 1'b0, 32'h0, "fill");
      run_xfer(32'h5200_0000, 2'b10, 0, 1'b0, 32'h0, "sat");
      // Clear coinciding with the final ERROR cycle.
      HSEL = 1'b1; HADDR = 32'h5100_0000; HTRANS = 2'b10;
      push(1'b1, 1'b0, DB); mid(); pop_check("clr_addr"); nxt();
      HSEL = 1'b0; HTRANS = 2'b00;
      push(1'b0, 1'b1, DB); mid(); pop_check("clr_err1"); nxt();
      CLR_ERR = 1'b1;
      push(1'b1, 1'b1, DB); mid(); pop_check("clr_err2"); nxt();
      CLR_ERR = 1'b0;
      m_err = 0; m_last = '0;
      push(1'b1, 1'b0, DB); mid(); pop_check("clr_idle"); check_log("clr_err"); nxt();
   endtask

   task automatic test_back_to_back();
      // OKAY to slave0 with the slave3 address accepted in its final data cycle.
      HSEL = 1'b1; HADDR = 32'h6000_0000; HTRANS = 2'b10;
      push(1'b1, 1'b0, DB); mid(); pop_check("b2b_a0"); check_sel("b2b_sel0", 4'b0001); nxt();
      HADDR = 32'h7000_0000;
      S_HRDATA[0*32 +: 32] = 32'h0A0A_0A0A;
      push(1'b1, 1'b0, 32'h0A0A_0A0A); mid(); pop_check("b2b_d0"); check_sel("b2b_sel3", 4'b1000); nxt();
      HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0;
      S_HRDATA[3*32 +: 32] = 32'h3333_3333;
      push(1'b1, 1'b0, 32'h3333_3333); mid(); pop_check("b2b_d3"); nxt();
      // Default-slave error, next address held until ERR2 completes.
      HSEL = 1'b1; HADDR = 32'h5000_0000; HTRANS = 2'b10;
      push(1'b1, 1'b0, DB); mid(); pop_check("b2e_a"); nxt();
      HADDR = 32'h6000_0020;
      push(1'b0, 1'b1, DB); mid(); pop_check("b2e_err1"); check_sel("b2e_sel", 4'b0001); nxt();
      push(1'b1, 1'b1, DB); mid(); pop_check("b2e_err2"); nxt();
      bump_err(32'h5000_0000);
      HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0;
      S_HRDATA[0*32 +: 32] = 32'h0B0B_0B0B;
      push(1'b1, 1'b0, 32'h0B0B_0B0B); mid(); pop_check("b2e_d0"); check_log("b2e_log"); nxt();
      push(1'b1, 1'b0, DB); mid(); pop_check("b2e_idle"); nxt();
   endtask

   task automatic test_reset_mid();
      run_xfer(32'h4000_0000, 2'b10, 100, 1'b0, 32'h4444_0000, "pre_rst_to");
      HSEL = 1'b1; HADDR = 32'h5000_0000; HTRANS = 2'b10;
      push(1'b1, 1'b0, DB); mid(); pop_check("rst_addr"); nxt();
      HSEL = 1'b0; HTRANS = 2'b00;
      push(1'b0, 1'b1, DB); mid(); pop_check("rst_err1");
      #1 HRESETn = 1'b0;
      #1;
      m_hung = '0; m_err = 0; m_last = '0;
      total++;
      if ({HREADYOUT, HRESP, HRDATA, TO_IRQ} !== {1'b1, 1'b0, DB, 1'b0}) begin
         bad++;
         $display("FAIL rst_mid_bus: got rdy=%b resp=%b data=%h irq=%b", HREADYOUT, HRESP, HRDATA, TO_IRQ);
      end
      check_log("rst_mid_log");
      nxt();
      nxt();
      HRESETn = 1'b1;
      nxt();
      run_xfer(32'h4000_0008, 2'b10, 0, 1'b0, 32'h4444_1111, "post_rst");
   endtask

   initial begin
      for (int i = 0; i < NS; i++) S_HRDATA[i*32 +: 32] = 32'h5A00_0000 + i;
      test_reset();
      test_basic();
      test_default();
      test_timeout();
      test_slave_err();
      test_back_to_back();
      test_reset_mid();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL time_limit: simulation ran past 500000, want finish earlier");
      $fatal(1);
   end

endmodule

// File: doc/ahb_splitter_n.md
Name: ahb_splitter_n

Overview:
Parametrised AHB-Lite slave-side splitter and decoder, the successor to the fixed three-way page decoder. It fans one AHB slave interface out to NS downstream slaves, each selected by a programmable address page. It adds what the fixed decoder lacks: a protocol-correct default slave (two-cycle ERROR response), a per-slave wait-state timeout watchdog with sticky hung-slave isolation, and error bookkeeping. It sits between the bus matrix and the peripheral/SRAM/APB-bridge slaves.

Parameters:
NS, 4, number of downstream slaves (1..16)
PAGE_HI, 31, MSB of the decoded address field
PAGE_LO, 24, LSB of the decoded address field; PW = PAGE_HI-PAGE_LO+1
PAGE_BASES, {8'h70,8'h40,8'h48,8'h60}, NS*PW packed page values; slave i uses bits [i*PW +: PW]
TIMEOUT, 16, maximum consecutive wait cycles per transfer; 0 disables the watchdog
CW, 8, width of the error counter

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  splitter selected
HADDR  in  32  address-phase address
HTRANS  in  2  transfer type
HREADY  in  1  bus ready
HREADYOUT  out  1  ready to the bus
HRDATA  out  32  read data to the bus
HRESP  out  1  response to the bus (1 = ERROR)
S_HSEL  out  NS  per-slave select
S_HREADYOUT  in  NS  per-slave ready
S_HRDATA  in  NS*32  per-slave read data; slave i uses bits [i*32 +: 32]
S_HRESP  in  NS  per-slave response
HUNG  out  NS  sticky flags for timed-out slaves
CLR_HUNG  in  1  synchronous clear of all HUNG bits
TO_IRQ  out  1  one-cycle pulse on any timeout
ERR_CNT  out  CW  saturating count of completed ERROR responses
LAST_ERR_ADDR  out  32  address of the most recent erroring transfer
CLR_ERR  in  1  synchronous clear of ERR_CNT and LAST_ERR_ADDR

Behaviour:
- Decode (combinational): match[i] = HADDR[PAGE_HI:PAGE_LO] == PAGE_BASES slice i. On multiple matches the lowest index wins.
- S_HSEL[i] = HSEL & match[i] & ~HUNG[i]. Not gated by HTRANS.
- Accept: acc = HSEL & HREADY & HTRANS[1]. On acc, register: the data-phase owner (index, or DEFAULT if no unhung match) and HADDR into AADDR.
- IDLE/BUSY transfers, and cycles where HSEL=0 with HREADY=1, clear the owner to NONE.
- FSM states:
  - NONE: HREADYOUT=1, HRESP=0, HRDATA=32'hDEADBEEF.
  - PASS(i): HREADYOUT, HRESP and HRDATA come from slave i.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1, HRDATA=32'hDEADBEEF.
- Transitions:
  - acc with owner DEFAULT -> ERR1; ERR1 -> ERR2 unconditionally.
  - ERR2 and PASS-complete (S_HREADYOUT[i]=1) behave like NONE: go to the next owner if acc, else NONE.
- Watchdog: counter cleared on entry to PASS; increments each PASS cycle with S_HREADYOUT[i]=0.
  - When TIMEOUT!=0, counter==TIMEOUT-1 and the slave is still not ready: next state ERR1, HUNG[i] set, TO_IRQ pulses for 1 cycle.
  - The data phase is therefore TIMEOUT wait cycles followed by ERR1 and ERR2. Late responses from slave i are ignored.
- Slave ERROR: a slave's own two-cycle error is passed through unchanged.
- Error bookkeeping: on the final cycle of any ERROR response (HREADYOUT=1 & HRESP=1), ERR_CNT increments (saturating at 2^CW-1) and LAST_ERR_ADDR <= AADDR.
  - CLR_ERR has priority over the same-cycle increment.
  - CLR_HUNG has priority over a same-cycle HUNG set.
- Reset values: state NONE, counter 0, HUNG=0, ERR_CNT=0, LAST_ERR_ADDR=0, TO_IRQ=0. Hence HREADYOUT=1, HRESP=0, HRDATA=DEADBEEF.
- Asynchronous reset mid-transfer (including during ERR1) returns all state immediately.
- Latency: zero added cycles on the OKAY path; decode is combinational and the owner register adds no wait state.

Test Plan:
1. NS=4, defaults; NONSEQ read at 0x6000_0010, slave0 ready with data 0x12345678 -> S_HSEL=4'b0001 in the address phase; next cycle HRDATA=0x12345678, HREADYOUT=1, HRESP=0.
2. NONSEQ to 0x5000_0000 -> S_HSEL=0; then HREADYOUT=0/HRESP=1 followed by HREADYOUT=1/HRESP=1; ERR_CNT=1; LAST_ERR_ADDR=0x5000_0000. Same access with HTRANS=IDLE -> OKAY, zero wait, ERR_CNT unchanged.
3. Slave1 (0x48) holds HREADYOUT=0 -> after 16 wait cycles, ERR1 then ERR2; TO_IRQ high for 1 cycle; HUNG=4'b0010. Next access to 0x4800_0000 -> S_HSEL=0 and an ERROR response. After CLR_HUNG, the same access selects slave1 with OKAY.
4. Slave2 returns its own two-cycle ERROR -> passed through; ERR_CNT increments by exactly 1. Force ERR_CNT to 255 and trigger another error -> ERR_CNT stays at 255. CLR_ERR asserted together with an error end -> ERR_CNT=0.
5. Pipelined: address phase to 0x7000_0000 accepted in slave0's final data cycle -> S_HSEL=4'b1000 in that cycle; next cycle HRDATA comes from slave3. Repeat with an error transfer followed immediately by a valid one.
6. Assert HRESETn low during ERR1 -> immediately HREADYOUT=1, HRESP=0, HUNG=0, ERR_CNT=0.
